// File: rtl/hex_disp_pkg.sv
// Shared definitions for the hex display arbiter: FSM state encoding and
// default timing constants for a 100 MHz system clock.
package hex_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BLANK = 2'd2
  } state_t;

  // 1 s of on-screen time and 1 ms of blanking at 100 MHz
  localparam int DEF_MIN_HOLD     = 100_000_000;
  localparam int DEF_BLANK_CYCLES = 100_000;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first asserted request
// found when scanning from ptr upward, wrapping modulo NREQ.
module rr_priority_picker #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            any_req
);

  // Scan offsets from farthest to nearest so the nearest hit to ptr wins
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        winner = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Time-shares one 4-digit hex 7-segment display among NREQ requesters.
// Owners are picked round-robin, shown for at least MIN_HOLD cycles, and
// separated by BLANK_CYCLES of dark display so digits do not ghost.
module hex_display_arbiter
  import hex_disp_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DW           = 16,
  parameter int MIN_HOLD     = DEF_MIN_HOLD,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  localparam int IW          = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  gnt,
  output logic [IW-1:0]    active_id,
  output logic [DW-1:0]    disp_data,
  output logic             disp_blank
);

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [HW-1:0]   hold_cnt;
  logic [BW-1:0]   blank_cnt;

  logic [IW-1:0]   winner;
  logic            any_req;
  logic            owner_req;
  logic            others_req;
  logic            hold_met;
  logic [DW-1:0]   owner_data;
  logic [DW-1:0]   winner_data;
  logic [IW-1:0]   next_ptr;

  rr_priority_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // Owner-relative views of the request bus; gnt is one-hot on the owner in GRANT
  always_comb begin
    owner_req   = req[active_id];
    others_req  = |(req & ~gnt);
    hold_met    = (hold_cnt == HW'(MIN_HOLD));
    owner_data  = req_data[int'(active_id)*DW +: DW];
    winner_data = req_data[int'(winner)*DW +: DW];
    next_ptr    = (active_id == IW'(NREQ - 1)) ? '0 : active_id + IW'(1);
  end

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      active_id  <= '0;
      disp_data  <= '0;
      disp_blank <= 1'b1;
      ptr        <= '0;
      hold_cnt   <= '0;
      blank_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt        <= NREQ'(1) << winner;
            active_id  <= winner;
            disp_data  <= winner_data;
            disp_blank <= 1'b0;
            hold_cnt   <= HW'(1);
            state      <= GRANT;
          end
        end
        GRANT: begin
          // Leave only once the hold is met and someone else wants the
          // display, or the owner has let go
          if (hold_met && (!owner_req || others_req)) begin
            gnt        <= '0;
            disp_blank <= 1'b1;
            ptr        <= next_ptr;
            blank_cnt  <= BW'(1);
            state      <= BLANK;
          end else begin
            if (!hold_met) begin
              hold_cnt <= hold_cnt + HW'(1);
            end
            // Live update while the owner requests; freeze otherwise
            if (owner_req) begin
              disp_data <= owner_data;
            end
          end
        end
        BLANK: begin
          if (blank_cnt == BW'(BLANK_CYCLES)) begin
            state <= IDLE;
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          gnt        <= '0;
          disp_blank <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter (NREQ=3, MIN_HOLD=4, BLANK_CYCLES=2).
module tb_hex_display_arbiter;

  localparam int NREQ         = 3;
  localparam int DW           = 16;
  localparam int MIN_HOLD     = 4;
  localparam int BLANK_CYCLES = 2;

  logic            clk;
  logic            rst_n;
  logic [2:0]      req;
  logic [47:0]     req_data;
  logic [2:0]      gnt;
  logic [1:0]      active_id;
  logic [15:0]     disp_data;
  logic            disp_blank;

  typedef struct packed {
    logic [2:0]  gnt;
    logic [1:0]  id;
    logic [15:0] data;
    logic        blank;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: who owns the display, how long it has been shown,
  // how much darkness remains, and where the next search starts
  int          m_owner;
  int          m_held;
  int          m_dark;
  int          m_ptr;
  logic [1:0]  m_id;
  logic [15:0] m_data;

  hex_display_arbiter #(
    .NREQ         (NREQ),
    .DW           (DW),
    .MIN_HOLD     (MIN_HOLD),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .active_id  (active_id),
    .disp_data  (disp_data),
    .disp_blank (disp_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    n_checks++;
    if (act === req_v) n_pass++;
    else $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req_v);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_dark  = 0;
    m_ptr   = 0;
    m_id    = '0;
    m_data  = '0;
  endtask

  // One clock edge of the arbiter's rules, applied to the sampled inputs
  task automatic model_step(input logic [2:0] r, input logic [47:0] d, input logic rn);
    bit others;
    int i;
    if (!rn) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      others = 0;
      for (int j = 0; j < NREQ; j++) if (j != m_owner && r[j]) others = 1;
      if (m_held >= MIN_HOLD && (!r[m_owner] || others)) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_dark  = BLANK_CYCLES;
      end else begin
        if (r[m_owner]) m_data = d[m_owner*16 +: 16];
        if (m_held < MIN_HOLD) m_held++;
      end
    end else if (m_dark > 0) begin
      m_dark--;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (r[i]) begin
          m_owner = i;
          m_id    = 2'(i);
          m_data  = d[i*16 +: 16];
          m_held  = 1;
          break;
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.gnt   = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    e.id    = m_id;
    e.data  = m_data;
    e.blank = (m_owner < 0);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus and predict the outputs after the next edge
  task automatic cycle(input logic [2:0] r, input logic [47:0] d, input logic rn);
    @(negedge clk);
    rst_n    = rn;
    req      = r;
    req_data = d;
    model_step(r, d, rn);
    push_expected();
  endtask

  // Assert reset in the middle of a cycle and confirm the outputs drop at once
  task automatic async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("rst_gnt",   64'(gnt),        64'(3'b000));
    chk("rst_blank", 64'(disp_blank), 64'(1'b1));
    chk("rst_data",  64'(disp_data),  64'(16'h0000));
    chk("rst_id",    64'(active_id),  64'(2'd0));
    model_step(req, req_data, 1'b0);
    push_expected();
  endtask

  function automatic logic [47:0] rnd_data();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  // Monitor: compare DUT outputs against the oldest prediction after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",        64'(gnt),        64'(e.gnt));
        chk("active_id",  64'(active_id),  64'(e.id));
        chk("disp_data",  64'(disp_data),  64'(e.data));
        chk("disp_blank", 64'(disp_blank), 64'(e.blank));
      end
    end
  end

  // Stimulus
  initial begin
    logic [2:0] r;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    model_reset();
    repeat (2) cycle(3'b000, 48'h0, 1'b0);
    repeat (2) cycle(3'b000, 48'h0, 1'b1);

    // Single requester with live data change, then release
    repeat (3) cycle(3'b001, {32'h0, 16'h1234}, 1'b1);
    repeat (3) cycle(3'b001, {32'h0, 16'hBEEF}, 1'b1);
    repeat (5) cycle(3'b000, {32'h0, 16'hBEEF}, 1'b1);

    // Early release: display freezes and stays lit until the hold is met
    repeat (2) cycle(3'b001, {32'h0, 16'hAAAA}, 1'b1);
    repeat (8) cycle(3'b000, {32'h0, 16'h5555}, 1'b1);

    // Full contention rotates through all owners
    repeat (30) cycle(3'b111, rnd_data(), 1'b1);
    repeat (6) cycle(3'b000, rnd_data(), 1'b1);

    // Leave ptr at 2, then a simultaneous 0/1 request must wrap to 0
    cycle(3'b010, rnd_data(), 1'b1);
    repeat (8) cycle(3'b000, rnd_data(), 1'b1);
    repeat (3) cycle(3'b011, rnd_data(), 1'b1);
    repeat (8) cycle(3'b000, rnd_data(), 1'b1);

    // A one-cycle pulse inside BLANK is dropped; a held request is served
    cycle(3'b001, rnd_data(), 1'b1);
    repeat (4) cycle(3'b000, rnd_data(), 1'b1);
    cycle(3'b010, rnd_data(), 1'b1);
    repeat (6) cycle(3'b000, rnd_data(), 1'b1);
    cycle(3'b001, rnd_data(), 1'b1);
    repeat (4) cycle(3'b000, rnd_data(), 1'b1);
    repeat (5) cycle(3'b010, rnd_data(), 1'b1);
    repeat (8) cycle(3'b000, rnd_data(), 1'b1);

    // Reset in the middle of a grant, then stay idle with no request
    repeat (3) cycle(3'b111, rnd_data(), 1'b1);
    async_reset();
    cycle(3'b000, rnd_data(), 1'b0);
    repeat (4) cycle(3'b000, rnd_data(), 1'b1);

    // Randomized traffic with occasional resets
    r = 3'b000;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < NREQ; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 149) == 0) cycle(r, rnd_data(), 1'b0);
      else cycle(r, rnd_data(), 1'b1);
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
